axis_uart_rx: RTL and testbench

UART receiver that turns an asynchronous 8N1 serial line into an AXI-Stream byte stream. It is the counterpart of the UART transmitter on the same link: it samples `rx_i` at mid-bit, checks the stop bit, and presents each good frame on an `axis_if` master port with a one-entry holding register. Framing errors and overruns are flagged as single-cycle pulses for status logging.

---
 rtl/axis_if.sv | 11 +
 rtl/axis_uart_rx.sv | 115 +++++++++++
 tb/tb_axis_uart_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_if.sv
// AXI-Stream link carrying tdata/tvalid/tready between a byte source and its consumer.
interface axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// UART 8N1 receiver: mid-bit sampling, stop-bit check, AXI-Stream out through a one-entry holding register.
// Latency: stop-sample edge is t0+2+HALF+(DATA_WIDTH+1)*RATIO; a full register with tready low drops the new frame (overrun pulse).
module axis_uart_rx #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic   clk_i,
  input  logic   arstn_i,
  input  logic   rx_i,
  axis_if.master m_axis,
  output logic   frame_err_o,
  output logic   overrun_o
);

  localparam int RATIO = CLK_FREQ / BAUD_RATE;
  localparam int HALF  = RATIO / 2;
  localparam int CNT_W = $clog2(RATIO);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATIO - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [CNT_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] data;
  logic                  vld;
  logic                  frame_err;
  logic                  overrun;

  // rx_i is asynchronous; only the second flop feeds the FSM.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) sync <= 2'b11;
    else          sync <= {sync[0], rx_i};
  end
  assign rx_s = sync[1];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      vld       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A good frame in the STOP branch below overrides this clear.
      if (vld && m_axis.tready) vld <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (baud_cnt == CNT_HALF) begin
            baud_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == CNT_FULL) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[DATA_WIDTH-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (baud_cnt == CNT_FULL) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (!vld || m_axis.tready) begin
              data <= shift;
              vld  <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = data;
  assign m_axis.tvalid = vld;
  assign frame_err_o   = frame_err;
  assign overrun_o     = overrun;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed bench for axis_uart_rx: table of single frames plus glitch, overrun, back-to-back and mid-frame reset sequences.
module tb_axis_uart_rx;

  localparam int RATIO = 27_000_000 / 115_200;
  localparam int HALF  = RATIO / 2;
  localparam int LAT   = 2 + HALF + 9 * RATIO;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic rx = 1'b1;
  logic tready = 1'b1;
  logic ferr, ovr;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  axis_if #(.DATA_WIDTH(8)) axis ();
  assign axis.tready = tready;

  axis_uart_rx #(
    .CLK_FREQ(27_000_000),
    .BAUD_RATE(115_200),
    .DATA_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .rx_i(rx),
    .m_axis(axis),
    .frame_err_o(ferr),
    .overrun_o(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   rise_q[$];
  int   hs_q[$];
  int   ferr_q[$];
  int   ovr_q[$];
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (arstn) begin
      if (axis.tvalid && !prev_v) rise_q.push_back(cyc);
      if (axis.tvalid && tready)  hs_q.push_back(int'(axis.tdata));
      if (ferr) ferr_q.push_back(cyc);
      if (ovr)  ovr_q.push_back(cyc);
    end
    prev_v = axis.tvalid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic clr();
    rise_q.delete(); hs_q.delete(); ferr_q.delete(); ovr_q.delete();
  endtask

  task automatic wait_bit();
    repeat (RATIO) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    @(posedge clk); #1;
    rx = 1'b0;
    t0 = cyc + 1;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_bit();
    end
    rx = stop;
    wait_bit();
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       good;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #(10 * 100_000 * 1ns);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;

    tbl[0] = '{8'hA5, 1'b1, 1'b1};
    tbl[1] = '{8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h5A, 1'b1, 1'b1};
    tbl[3] = '{8'h81, 1'b1, 1'b1};
    tbl[4] = '{8'h3C, 1'b1, 1'b1};

    // Reset held with the line toggling.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rx = ~rx;
    end
    @(negedge clk);
    chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("rst_tdata", 32'(axis.tdata), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    @(posedge clk); #1;
    rx = 1'b1;
    idle(3);
    arstn = 1'b1;
    idle(1000);
    chk("idle_rise", 32'(rise_q.size()), 32'd0);
    chk("idle_ferr", 32'(ferr_q.size()), 32'd0);

    // Table of single frames, tready always high.
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clr();
      send_frame(tbl[k].d, tbl[k].stop, t0);
      idle(RATIO);
      if (tbl[k].good) begin
        chk($sformatf("v%0d_rise_cyc", k), 32'(first(rise_q)), 32'(t0 + LAT));
        chk($sformatf("v%0d_hs_cnt", k), 32'(hs_q.size()), 32'd1);
        chk($sformatf("v%0d_data", k), 32'(first(hs_q)), 32'(tbl[k].d));
        chk($sformatf("v%0d_ferr_cnt", k), 32'(ferr_q.size()), 32'd0);
      end else begin
        chk($sformatf("v%0d_ferr_cnt", k), 32'(ferr_q.size()), 32'd1);
        chk($sformatf("v%0d_ferr_cyc", k), 32'(first(ferr_q)), 32'(t0 + LAT));
        chk($sformatf("v%0d_no_valid", k), 32'(rise_q.size()), 32'd0);
      end
      chk($sformatf("v%0d_ovr_cnt", k), 32'(ovr_q.size()), 32'd0);
    end

    // Start glitch shorter than half a bit, then a real frame.
    clr();
    @(posedge clk); #1;
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(3 * RATIO);
    chk("glitch_rise", 32'(rise_q.size()), 32'd0);
    chk("glitch_ferr", 32'(ferr_q.size()), 32'd0);
    send_frame(8'h3C, 1'b1, t0);
    idle(RATIO);
    chk("glitch_next_data", 32'(first(hs_q)), 32'h3C);
    chk("glitch_next_cyc", 32'(first(rise_q)), 32'(t0 + LAT));

    // Overrun: second frame arrives with the register still full.
    clr();
    tready = 1'b0;
    send_frame(8'h11, 1'b1, t0);
    send_frame(8'h22, 1'b1, t1);
    idle(RATIO);
    chk("ovr_tvalid", 32'(axis.tvalid), 32'd1);
    chk("ovr_tdata", 32'(axis.tdata), 32'h11);
    chk("ovr_cnt", 32'(ovr_q.size()), 32'd1);
    chk("ovr_cyc", 32'(first(ovr_q)), 32'(t1 + LAT));
    tready = 1'b1;
    idle(5);
    chk("ovr_hs_cnt", 32'(hs_q.size()), 32'd1);
    chk("ovr_hs_data", 32'(first(hs_q)), 32'h11);
    chk("ovr_tvalid_drop", 32'(axis.tvalid), 32'd0);

    // Back-to-back frames.
    clr();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    send_frame(8'h55, 1'b1, t2);
    idle(RATIO);
    chk("b2b_cnt", 32'(hs_q.size()), 32'd3);
    if (hs_q.size() == 3) begin
      chk("b2b_d0", 32'(hs_q[0]), 32'h00);
      chk("b2b_d1", 32'(hs_q[1]), 32'hFF);
      chk("b2b_d2", 32'(hs_q[2]), 32'h55);
    end
    chk("b2b_last_cyc", 32'((rise_q.size() == 3) ? rise_q[2] : -1), 32'(t2 + LAT));
    chk("b2b_ferr", 32'(ferr_q.size()), 32'd0);

    // Reset asserted during data bit 4 of a 0x99 frame.
    clr();
    @(posedge clk); #1;
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rx = 1'((8'h99 >> i) & 8'h01);
      wait_bit();
    end
    rx = 1'b1;
    idle(HALF);
    arstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(axis.tdata), 32'd0);
    idle(5);
    arstn = 1'b1;
    idle(12 * RATIO);
    chk("mid_rst_no_out", 32'(rise_q.size()), 32'd0);
    chk("mid_rst_no_ferr", 32'(ferr_q.size()), 32'd0);
    send_frame(8'hC3, 1'b1, t0);
    idle(RATIO);
    chk("mid_rst_next_data", 32'(first(hs_q)), 32'hC3);
    chk("mid_rst_next_cyc", 32'(first(rise_q)), 32'(t0 + LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
